snd_mem_arbiter: RTL and testbench

//  Shares the single-port 128 KiB x 8 block RAM (blk_mem_gen_0) between the TG68 (68000) core and the Z80.

---
 rtl/snd_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_snd_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snd_mem_arbiter.sv
// snd_mem_arbiter: shares the sound block RAM between the 68000 and the Z80.
// Define SND_MEM_ARB_Z80_PRIO_EN to give the Z80 fixed priority on ties.
module snd_mem_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m68_req,
    input  logic        m68_we,
    input  logic [16:0] m68_addr,
    input  logic [7:0]  m68_wdata,
    output logic        m68_ack,
    output logic [7:0]  m68_rdata,
    input  logic        z80_req,
    input  logic        z80_we,
    input  logic [15:0] z80_addr,
    input  logic [7:0]  z80_wdata,
    output logic        z80_ack,
    output logic [7:0]  z80_rdata,
    output logic        z80_nwait,
    output logic        mem_ena,
    output logic        mem_wea,
    output logic [16:0] mem_addra,
    output logic [7:0]  mem_dina,
    input  logic [7:0]  mem_douta
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_e;

    localparam logic [2:0] CNT_LAST = 3'(RD_LAT - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        gnt_z80_q, gnt_z80_d;
    logic        mem_ena_q, mem_ena_d;
    logic        mem_wea_q, mem_wea_d;
    logic [16:0] mem_addra_q, mem_addra_d;
    logic [7:0]  mem_dina_q, mem_dina_d;
    logic        m68_ack_q, m68_ack_d;
    logic        z80_ack_q, z80_ack_d;
    logic [7:0]  m68_rdata_q, m68_rdata_d;
    logic [7:0]  z80_rdata_q, z80_rdata_d;
    logic        any_req;
    logic        pick_z80;
    logic        rd_done;

    always_comb begin
        any_req = m68_req | z80_req;
`ifdef SND_MEM_ARB_Z80_PRIO_EN
        pick_z80 = z80_req;
`else
        // gnt_z80_q doubles as last_grant: on a tie, serve the other side
        pick_z80 = z80_req & (~m68_req | ~gnt_z80_q);
`endif
        rd_done = (state_q == S_WAIT) && (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        gnt_z80_d   = gnt_z80_q;
        mem_ena_d   = 1'b0;
        mem_wea_d   = 1'b0;
        mem_addra_d = mem_addra_q;
        mem_dina_d  = mem_dina_q;
        m68_ack_d   = 1'b0;
        z80_ack_d   = 1'b0;
        m68_rdata_d = m68_rdata_q;
        z80_rdata_d = z80_rdata_q;
        if (state_q == S_IDLE && any_req) begin
            gnt_z80_d = pick_z80;
            mem_ena_d = 1'b1;
            if (pick_z80) begin
                mem_wea_d   = z80_we;
                mem_addra_d = {1'b1, z80_addr};
                mem_dina_d  = z80_wdata;
            end else begin
                mem_wea_d   = m68_we;
                mem_addra_d = m68_addr;
                mem_dina_d  = m68_wdata;
            end
        end
        if (rd_done) begin
            if (gnt_z80_q) begin
                z80_rdata_d = mem_douta;
                z80_ack_d   = 1'b1;
            end else begin
                m68_rdata_d = mem_douta;
                m68_ack_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_z80_q   <= 1'b1;
            mem_ena_q   <= 1'b0;
            mem_wea_q   <= 1'b0;
            mem_addra_q <= '0;
            mem_dina_q  <= '0;
            m68_ack_q   <= 1'b0;
            z80_ack_q   <= 1'b0;
            m68_rdata_q <= '0;
            z80_rdata_q <= '0;
        end else begin
            gnt_z80_q   <= gnt_z80_d;
            mem_ena_q   <= mem_ena_d;
            mem_wea_q   <= mem_wea_d;
            mem_addra_q <= mem_addra_d;
            mem_dina_q  <= mem_dina_d;
            m68_ack_q   <= m68_ack_d;
            z80_ack_q   <= z80_ack_d;
            m68_rdata_q <= m68_rdata_d;
            z80_rdata_q <= z80_rdata_d;
        end
    end

    assign mem_ena   = mem_ena_q;
    assign mem_wea   = mem_wea_q;
    assign mem_addra = mem_addra_q;
    assign mem_dina  = mem_dina_q;
    assign m68_ack   = m68_ack_q;
    assign z80_ack   = z80_ack_q;
    assign m68_rdata = m68_rdata_q;
    assign z80_rdata = z80_rdata_q;
    // Held high through reset so an aborted access never stalls the Z80
    assign z80_nwait = ~(z80_req & ~z80_ack_q & rst_n);

endmodule

// File: tb/tb_snd_mem_arbiter.sv
// tb_snd_mem_arbiter: directed checks of the sound RAM arbiter.
// Two instances: RD_LAT=1 (main) and RD_LAT=3 (latency check).
module tb_snd_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    logic        m68_req, m68_we, m68_ack;
    logic [16:0] m68_addr;
    logic [7:0]  m68_wdata, m68_rdata;
    logic        z80_req, z80_we, z80_ack, z80_nwait;
    logic [15:0] z80_addr;
    logic [7:0]  z80_wdata, z80_rdata;
    logic        mem_ena, mem_wea;
    logic [16:0] mem_addra;
    logic [7:0]  mem_dina, mem_douta;

    logic        b_m68_req, b_m68_we, b_m68_ack;
    logic [16:0] b_m68_addr;
    logic [7:0]  b_m68_wdata, b_m68_rdata;
    logic        b_z80_req, b_z80_we, b_z80_ack, b_z80_nwait;
    logic [15:0] b_z80_addr;
    logic [7:0]  b_z80_wdata, b_z80_rdata;
    logic        b_ena, b_wea;
    logic [16:0] b_addra;
    logic [7:0]  b_dina, b_douta;

    snd_mem_arbiter #(.RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .m68_req(m68_req), .m68_we(m68_we), .m68_addr(m68_addr),
        .m68_wdata(m68_wdata), .m68_ack(m68_ack), .m68_rdata(m68_rdata),
        .z80_req(z80_req), .z80_we(z80_we), .z80_addr(z80_addr),
        .z80_wdata(z80_wdata), .z80_ack(z80_ack), .z80_rdata(z80_rdata),
        .z80_nwait(z80_nwait),
        .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra),
        .mem_dina(mem_dina), .mem_douta(mem_douta)
    );

    snd_mem_arbiter #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .m68_req(b_m68_req), .m68_we(b_m68_we), .m68_addr(b_m68_addr),
        .m68_wdata(b_m68_wdata), .m68_ack(b_m68_ack), .m68_rdata(b_m68_rdata),
        .z80_req(b_z80_req), .z80_we(b_z80_we), .z80_addr(b_z80_addr),
        .z80_wdata(b_z80_wdata), .z80_ack(b_z80_ack), .z80_rdata(b_z80_rdata),
        .z80_nwait(b_z80_nwait),
        .mem_ena(b_ena), .mem_wea(b_wea), .mem_addra(b_addra),
        .mem_dina(b_dina), .mem_douta(b_douta)
    );

    // RAM models: latency 1 (read-first) and latency 3
    logic [7:0] ram1 [0:131071];
    logic [7:0] q1;
    always @(posedge clk) begin
        if (mem_ena) begin
            if (mem_wea) ram1[mem_addra] <= mem_dina;
            q1 <= ram1[mem_addra];
        end
    end
    assign mem_douta = q1;

    logic [7:0] ram3 [0:131071];
    logic [7:0] p3 [0:2];
    always @(posedge clk) begin
        if (b_ena) begin
            if (b_wea) ram3[b_addra] <= b_dina;
            p3[0] <= ram3[b_addra];
        end
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign b_douta = p3[2];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m68_xfer1(input logic we, input logic [16:0] a,
                             input logic [7:0] d, output int lat,
                             output logic [7:0] rd);
        m68_we = we; m68_addr = a; m68_wdata = d; m68_req = 1'b1;
        lat = 0;
        while (lat < 30) begin
            tick(); lat++;
            if (m68_ack) break;
        end
        rd = m68_rdata;
        m68_req = 1'b0;
        tick();
    endtask

    task automatic m68_xfer3(input logic we, input logic [16:0] a,
                             input logic [7:0] d, output int lat,
                             output logic [7:0] rd);
        b_m68_we = we; b_m68_addr = a; b_m68_wdata = d; b_m68_req = 1'b1;
        lat = 0;
        while (lat < 30) begin
            tick(); lat++;
            if (b_m68_ack) break;
        end
        rd = b_m68_rdata;
        b_m68_req = 1'b0;
        tick();
    endtask

    task automatic wait_z80(output int n);
        n = 0;
        while (n < 30) begin
            tick(); n++;
            if (z80_ack) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int         lat, lat2, k, t, m68n, both;
    logic [7:0] rd, rd2;
    logic [3:0] seq;

    initial begin
        m68_req = 0; m68_we = 0; m68_addr = '0; m68_wdata = '0;
        z80_req = 0; z80_we = 0; z80_addr = '0; z80_wdata = '0;
        b_m68_req = 0; b_m68_we = 0; b_m68_addr = '0; b_m68_wdata = '0;
        b_z80_req = 0; b_z80_we = 0; b_z80_addr = '0; b_z80_wdata = '0;
        #2 rst_n = 1'b0;
        tick(); tick();
        chk("rst_ena", mem_ena, 0);
        chk("rst_wea", mem_wea, 0);
        chk("rst_addra", mem_addra, 0);
        chk("rst_dina", mem_dina, 0);
        chk("rst_acks", {m68_ack, z80_ack}, 0);
        chk("rst_rdata", {m68_rdata, z80_rdata}, 0);
        chk("rst_nwait", z80_nwait, 1);
        chk("rst3_ena_ack", {b_ena, b_m68_ack, b_z80_ack}, 0);
        rst_n = 1'b1;
        tick();

        // 68000 write 0x00005 = 0xA5
        m68_we = 1; m68_addr = 17'h00005; m68_wdata = 8'hA5; m68_req = 1;
        tick();
        chk("wr_ena", {mem_ena, mem_wea}, 2'b11);
        chk("wr_addra", mem_addra, 17'h00005);
        chk("wr_dina", mem_dina, 8'hA5);
        tick();
        chk("wr_ena_off", {mem_ena, mem_wea}, 0);
        chk("wr_ack_early", m68_ack, 0);
        tick();
        chk("wr_ack_at3", m68_ack, 1);
        m68_req = 0;
        tick();
        chk("wr_ack_pulse", m68_ack, 0);
        chk("wr_ram", ram1[17'h00005], 8'hA5);
        m68_xfer1(0, 17'h00005, 8'h00, lat, rd);
        chk("rdback_lat", lat, 3);
        chk("rdback_data", rd, 8'hA5);

        // 68000 fills the Z80 mailbox, Z80 reads it
        m68_xfer1(1, 17'h10003, 8'h80, lat, rd);
        z80_we = 0; z80_addr = 16'h0003; z80_req = 1;
        #1 chk("z_nwait_req", z80_nwait, 0);
        tick();
        chk("z_ena", {mem_ena, mem_wea}, 2'b10);
        chk("z_addra", mem_addra, 17'h10003);
        tick();
        chk("z_wait", {z80_ack, z80_nwait}, 0);
        tick();
        chk("z_ack", {z80_ack, z80_nwait}, 2'b11);
        chk("z_rdata", z80_rdata, 8'h80);
        z80_req = 0;
        tick();
        chk("z_ack_pulse", z80_ack, 0);
        chk("z_rdata_hold", z80_rdata, 8'h80);
        chk("z_nwait_idle", z80_nwait, 1);

        // Simultaneous continuous requests
        m68_we = 0; m68_addr = 17'h00100; m68_req = 1;
        z80_we = 0; z80_addr = 16'h0200; z80_req = 1;
        seq = '0; k = 0; t = 0; m68n = 0; both = 0;
        while (k < 4 && t < 40) begin
            tick(); t++;
            if (m68_ack && z80_ack) both++;
            if (m68_ack) begin
                m68n++;
                chk("rr_nwait_loser", z80_nwait, 0);
                seq[k] = 1'b0; k++;
            end else if (z80_ack) begin
                seq[k] = 1'b1; k++;
            end
        end
        m68_req = 0; z80_req = 0;
        tick();
        chk("rr_count", k, 4);
        chk("rr_both", both, 0);
`ifdef SND_MEM_ARB_Z80_PRIO_EN
        chk("prio_seq", seq, 4'b1111);
        chk("prio_m68n", m68n, 0);
`else
        chk("rr_seq", seq, 4'b1010);
        chk("rr_m68n", m68n, 2);
`endif

        // Back-to-back Z80 reads
        m68_xfer1(1, 17'h10000, 8'h06, lat, rd);
        m68_xfer1(1, 17'h10001, 8'h9A, lat, rd);
        z80_addr = 16'h0000; z80_req = 1;
        wait_z80(lat);
        rd = z80_rdata;
        z80_addr = 16'h0001;
        wait_z80(lat2);
        rd2 = z80_rdata;
        z80_req = 0;
        tick();
        chk("b2b_lat1", lat, 3);
        chk("b2b_gap", lat2, 4);
        chk("b2b_d0", rd, 8'h06);
        chk("b2b_d1", rd2, 8'h9A);

        // Reset during WAIT aborts; pending request re-granted
        m68_xfer1(1, 17'h10042, 8'h5C, lat, rd);
        z80_addr = 16'h0042; z80_req = 1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ena", {mem_ena, mem_wea}, 0);
        chk("mid_rst_acks", {m68_ack, z80_ack}, 0);
        chk("mid_rst_nwait", z80_nwait, 1);
        tick();
        chk("mid_rst_noack", z80_ack, 0);
        rst_n = 1'b1;
        wait_z80(lat);
        chk("regrant_lat", lat, 3);
        chk("regrant_data", z80_rdata, 8'h5C);
        z80_req = 0;
        tick();

        // RD_LAT=3 instance
        m68_xfer3(1, 17'h1FFFF, 8'h70, lat, rd);
        chk("lat3_wr_lat", lat, 5);
        m68_xfer3(0, 17'h1FFFF, 8'h00, lat, rd);
        chk("lat3_rd_lat", lat, 5);
        chk("lat3_rd_data", rd, 8'h70);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
